ls165_piso: RTL

- Cycle-accurate, system-clock-synchronous model of one or more cascaded 74LS165 8-bit parallel-in/serial-out shift registers.
- Transmit-side counterpart to the serial-in receiver chips in the TTL library. Used where original boards serialise ROM or graphics bytes onto a single line, such as tile and sprite pixel shifters.
- The emulated TTL clock arrives as an ordinary signal and is edge-detected against the single FPGA system clock. No derived clocks are created.

---
 rtl/ttl_pkg.sv | 15 +
 rtl/ttl_edge_det.sv | 33 +++
 rtl/ls165_piso.sv | 76 +++++++
 3 files changed

// File: rtl/ttl_pkg.sv
// ---------------------------------------------------------------------------
// ttl_pkg
// Shared definitions for the clocked 74-series TTL models.
//   TTL_BYTE   : width of one 8-bit TTL device
//   ttl_width  : total register width of a cascade of n byte-wide devices
// ---------------------------------------------------------------------------
package ttl_pkg;

  localparam int TTL_BYTE = 8;

  function automatic int ttl_width(input int num_chips);
    return TTL_BYTE * num_chips;
  endfunction

endpackage

// File: rtl/ttl_edge_det.sv
// ---------------------------------------------------------------------------
// ttl_edge_det
// Samples an emulated TTL signal on the system clock and flags its edges.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   d     : signal to watch (assumed synchronous to clk)
//   rise  : d is 1 now and was 0 at the previous clk edge
//   fall  : d is 0 now and was 1 at the previous clk edge
// RST_VAL sets the assumed previous value after reset.
// With RST_VAL=1, a signal that is already high at reset release is not
// reported as a rising edge.
// ---------------------------------------------------------------------------
module ttl_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= RST_VAL;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/ls165_piso.sv
// ---------------------------------------------------------------------------
// ls165_piso
// One or more cascaded 74LS165 parallel-in/serial-out shift registers.
// The model is cycle-accurate and runs on the single system clock. The TTL
// shift clock is edge-detected; it is never used as a real clock.
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   sh_ld_n : active-low parallel load. It is level-sensitive and has
//             priority over shift.
//   cp      : emulated TTL shift clock
//   clk_inh : clock inhibit. It is ORed with cp, as on the real part.
//   ser     : serial input, shifted into bit 0
//   p       : parallel data. p[8k+7:8k] maps to pins H..A of chip k.
//   qh      : serial output, which is the MSB of the chain
//   qh_n    : complement of qh
// ---------------------------------------------------------------------------
module ls165_piso
  import ttl_pkg::*;
#(
  parameter int NUM_CHIPS = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sh_ld_n,
  input  logic                              cp,
  input  logic                              clk_inh,
  input  logic                              ser,
  input  logic [ttl_width(NUM_CHIPS)-1:0]   p,
  output logic                              qh,
  output logic                              qh_n
);

  localparam int W = ttl_width(NUM_CHIPS);

  logic         gclk;
  logic         gclk_rise;
  logic         gclk_fall;
  logic [W-1:0] r;

  assign gclk = cp | clk_inh;

  // The edge detector keeps tracking the gated clock even while a load is
  // in progress. As a result, releasing sh_ld_n with the gated clock high
  // does not produce a shift.
  ttl_edge_det #(
    .RST_VAL (1'b1)
  ) u_gclk_edge (
    .clk   (clk),
    .reset (reset),
    .d     (gclk),
    .rise  (gclk_rise),
    .fall  (gclk_fall)
  );

  // A load takes precedence over a shift on the same edge.
  // The cascade falls out of one wide register: the H bit of chip k moves
  // into the A bit of chip k+1 on the same shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
    end else if (!sh_ld_n) begin
      r <= p;
    end else if (gclk_rise) begin
      r <= {r[W-2:0], ser};
    end
  end

  assign qh   = r[W-1];
  assign qh_n = ~r[W-1];

  // The falling-edge flag is not needed here. Consuming it keeps the
  // shared edge detector interface uniform across the TTL models.
  logic unused_fall;
  assign unused_fall = gclk_fall;

endmodule
